// File: rtl/pipeline_pkg.sv
// pipeline_pkg: shared constants and types for the UART GCD board block.
//   CLK_HZ / BAUD / BIT_CYC : default clock rate, UART rate, clocks per bit
//   state_t                 : control FSM states
//   SEG_TAB / hex_seg       : hex nibble -> active-low 7-segment pattern (bit0=a .. bit6=g)
package pipeline_pkg;

    localparam int CLK_HZ  = 50_000_000;
    localparam int BAUD    = 9600;
    localparam int BIT_CYC = CLK_HZ / BAUD;

    typedef enum logic [1:0] {WAIT_A, WAIT_B, CALC, SEND} state_t;

    // Entry 15 first so that SEG_TAB[n] selects digit n.
    localparam logic [15:0][6:0] SEG_TAB = {
        7'b0001110, 7'b0000110, 7'b0100001, 7'b1000110,  // F E d C
        7'b0000011, 7'b0001000, 7'b0010000, 7'b0000000,  // b A 9 8
        7'b1111000, 7'b0000010, 7'b0010010, 7'b0011001,  // 7 6 5 4
        7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000   // 3 2 1 0
    };

    function automatic logic [6:0] hex_seg(input logic [3:0] nib);
        return SEG_TAB[nib];
    endfunction

endpackage

// File: rtl/pipeline_if.sv
// pipeline_if: byte-level handshake between the control logic and the UART.
//   rx_valid/rx_byte : one-cycle pulse with a received byte
//   tx_start/tx_data : request to send a byte (honoured while tx_busy is low)
//   tx_busy          : high from the start bit until the end of the stop bit
//   master = controller side, slave = UART side
interface pipeline_if;
    logic       rx_valid;
    logic [7:0] rx_byte;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_busy;

    modport master (input  rx_valid, rx_byte, tx_busy, output tx_start, tx_data);
    modport slave  (output rx_valid, rx_byte, tx_busy, input  tx_start, tx_data);
endinterface

// File: rtl/pipeline_uart.sv
// pipeline_uart: 8N1 UART receiver and transmitter, LSB first.
//   clk, rst_n : clock, asynchronous active-low reset
//   rx_pin     : serial input (idle high), synchronised internally
//   tx_pin     : registered serial output (idle high)
//   bus        : byte handshake (slave side)
module pipeline_uart #(
    parameter int BIT_CYC = pipeline_pkg::BIT_CYC
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      rx_pin,
    output logic      tx_pin,
    pipeline_if.slave bus
);
    localparam int CW = $clog2(BIT_CYC);
    localparam logic [CW-1:0] FULL_M1 = CW'(BIT_CYC - 1);
    localparam logic [CW-1:0] HALF_M1 = CW'(BIT_CYC / 2 - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    // ---------------- receiver ----------------
    logic          rx_m, rx_s, rx_prev;
    rx_state_t     rx_state_q, rx_state_d;
    logic [CW-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]    rx_bit_q, rx_bit_d;
    logic [7:0]    rx_sh_q, rx_sh_d;
    logic          rx_vld_q, rx_vld_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_m       <= 1'b1;
            rx_s       <= 1'b1;
            rx_prev    <= 1'b1;
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_sh_q    <= '0;
            rx_vld_q   <= 1'b0;
        end else begin
            rx_m       <= rx_pin;
            rx_s       <= rx_m;
            rx_prev    <= rx_s;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_sh_q    <= rx_sh_d;
            rx_vld_q   <= rx_vld_d;
        end
    end

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q + CW'(1);
        rx_bit_d   = rx_bit_q;
        rx_sh_d    = rx_sh_q;
        rx_vld_d   = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                rx_cnt_d = '0;
                if (rx_prev && !rx_s) rx_state_d = RX_START;
            end
            RX_START: begin
                // Mid-start re-check rejects glitches shorter than half a bit.
                if (rx_cnt_q == HALF_M1) begin
                    rx_cnt_d   = '0;
                    rx_bit_d   = '0;
                    rx_state_d = rx_s ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (rx_cnt_q == FULL_M1) begin
                    rx_cnt_d = '0;
                    rx_sh_d  = {rx_s, rx_sh_q[7:1]};
                    rx_bit_d = rx_bit_q + 3'd1;
                    if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
                end
            end
            RX_STOP: begin
                // A low stop bit is a framing error: drop the byte silently.
                if (rx_cnt_q == FULL_M1) begin
                    rx_state_d = RX_IDLE;
                    rx_vld_d   = rx_s;
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    // rx_sh_q holds still from the stop bit until the next start bit.
    assign bus.rx_valid = rx_vld_q;
    assign bus.rx_byte  = rx_sh_q;

    // ---------------- transmitter ----------------
    logic [CW-1:0] tx_cnt;
    logic [3:0]    tx_bit;
    logic [8:0]    tx_sh;
    logic          tx_busy_q;

    // tx_bit counts the frame slot currently on the line: 0 = start, 9 = stop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_pin    <= 1'b1;
            tx_busy_q <= 1'b0;
            tx_cnt    <= '0;
            tx_bit    <= '0;
            tx_sh     <= '0;
        end else if (!tx_busy_q) begin
            if (bus.tx_start) begin
                tx_pin    <= 1'b0;
                tx_busy_q <= 1'b1;
                tx_sh     <= {1'b1, bus.tx_data};
                tx_cnt    <= '0;
                tx_bit    <= '0;
            end
        end else if (tx_cnt == FULL_M1) begin
            tx_cnt <= '0;
            if (tx_bit == 4'd9) begin
                tx_busy_q <= 1'b0;
            end else begin
                tx_pin <= tx_sh[0];
                tx_sh  <= {1'b1, tx_sh[8:1]};
                tx_bit <= tx_bit + 4'd1;
            end
        end else begin
            tx_cnt <= tx_cnt + CW'(1);
        end
    end

    assign bus.tx_busy = tx_busy_q;

endmodule

// File: rtl/pipeline.sv
// pipeline: board top. Receives operands A and B over UART, computes gcd(A,B)
// by repeated subtraction, shows values on LEDs / 7-segment digits and sends
// the result back over UART.
//   sysclk, reset    : system clock, asynchronous active-low reset
//   UART_RX, UART_TX : 8N1 serial in / out
//   switch[0]        : led source (1 = operand B, 0 = result)
//   led              : selected byte
//   digi1/digi2      : operand A high/low nibble, digi3/digi4 : result high/low
module pipeline #(
    parameter int CLK_HZ = pipeline_pkg::CLK_HZ,
    parameter int BAUD   = pipeline_pkg::BAUD
) (
    input  logic       sysclk,
    input  logic       reset,
    input  logic [7:0] switch,
    input  logic       UART_RX,
    output logic       UART_TX,
    output logic [7:0] led,
    output logic [6:0] digi1,
    output logic [6:0] digi2,
    output logic [6:0] digi3,
    output logic [6:0] digi4
);
    import pipeline_pkg::*;

    pipeline_if bus ();

    pipeline_uart #(.BIT_CYC(CLK_HZ / BAUD)) u_uart (
        .clk    (sysclk),
        .rst_n  (reset),
        .rx_pin (UART_RX),
        .tx_pin (UART_TX),
        .bus    (bus.slave)
    );

    state_t     state_q, state_d;
    logic [7:0] a_q, a_d, b_q, b_d, x_q, x_d, y_q, y_d, res_q, res_d;
    logic       fired_q, fired_d;   // tx_start already issued in this SEND
    logic       tx_start;

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            state_q <= WAIT_A;
            a_q     <= '0;
            b_q     <= '0;
            x_q     <= '0;
            y_q     <= '0;
            res_q   <= '0;
            fired_q <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            x_q     <= x_d;
            y_q     <= y_d;
            res_q   <= res_d;
            fired_q <= fired_d;
        end
    end

    // Bytes arriving in CALC/SEND are ignored simply by not looking at rx_valid.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        x_d      = x_q;
        y_d      = y_q;
        res_d    = res_q;
        fired_d  = fired_q;
        tx_start = 1'b0;
        case (state_q)
            WAIT_A: begin
                if (bus.rx_valid) begin
                    a_d     = bus.rx_byte;
                    state_d = WAIT_B;
                end
            end
            WAIT_B: begin
                if (bus.rx_valid) begin
                    b_d     = bus.rx_byte;
                    x_d     = a_q;
                    y_d     = bus.rx_byte;
                    res_d   = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                fired_d = 1'b0;
                if (x_q == 8'd0) begin
                    res_d   = y_q;
                    state_d = SEND;
                end else if (y_q == 8'd0 || x_q == y_q) begin
                    res_d   = x_q;
                    state_d = SEND;
                end else if (x_q > y_q) begin
                    x_d = x_q - y_q;
                end else begin
                    y_d = y_q - x_q;
                end
            end
            SEND: begin
                if (!fired_q) begin
                    tx_start = 1'b1;
                    fired_d  = 1'b1;
                end else if (!bus.tx_busy) begin
                    state_d = WAIT_A;
                end
            end
            default: state_d = WAIT_A;
        endcase
    end

    assign bus.tx_start = tx_start;
    assign bus.tx_data  = res_q;

    assign led   = switch[0] ? b_q : res_q;
    assign digi1 = hex_seg(a_q[7:4]);
    assign digi2 = hex_seg(a_q[3:0]);
    assign digi3 = hex_seg(res_q[7:4]);
    assign digi4 = hex_seg(res_q[3:0]);

    logic sw_unused;
    assign sw_unused = ^switch[7:1];

endmodule

// File: tb/tb_pipeline.sv
module tb_pipeline;
    // Scaled-down bit rate so whole frames fit a short run: 16 clocks per bit.
    localparam int CLK_HZ = 160;
    localparam int BAUD   = 10;
    localparam int BIT    = 16;

    localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100,
                           S3 = 7'b0110000, S6 = 7'b0000010, S7 = 7'b1111000,
                           S8 = 7'b0000000, SC = 7'b1000110, SF = 7'b0001110;

    logic       sysclk = 1'b0;
    logic       reset;
    logic [7:0] switch = 8'h00;
    logic       UART_RX = 1'b1;
    logic       UART_TX;
    logic [7:0] led;
    logic [6:0] digi1, digi2, digi3, digi4;

    always #5 sysclk = ~sysclk;

    pipeline #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) dut (
        .sysclk (sysclk),
        .reset  (reset),
        .switch (switch),
        .UART_RX(UART_RX),
        .UART_TX(UART_TX),
        .led    (led),
        .digi1  (digi1),
        .digi2  (digi2),
        .digi3  (digi3),
        .digi4  (digi4)
    );

    typedef struct {
        logic [7:0] res;
        logic [7:0] led;
        logic [6:0] d1, d2, d3, d4;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge sysclk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        UART_RX = 1'b0;
        cyc(BIT);
        for (int i = 0; i < 8; i++) begin
            UART_RX = b[i];
            cyc(BIT);
        end
        UART_RX = stop;
        cyc(BIT);
        UART_RX = 1'b1;
        cyc(2 * BIT);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (q.size() != 0 && n < 3000) begin
            cyc(1);
            n++;
        end
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL tx_timeout actual=%0d pending required=0", q.size());
            q.delete();
        end
        cyc(2 * BIT);
    endtask

    task automatic pair(input logic [7:0] a, input logic [7:0] b, input logic [7:0] sw,
                        input logic [7:0] res, input logic [7:0] l,
                        input logic [6:0] d1, input logic [6:0] d2,
                        input logic [6:0] d3, input logic [6:0] d4);
        exp_t e;
        e.res = res; e.led = l; e.d1 = d1; e.d2 = d2; e.d3 = d3; e.d4 = d4;
        switch = sw;
        q.push_back(e);
        send_byte(a, 1'b1);
        send_byte(b, 1'b1);
        wait_idle();
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_tx"},  {31'b0, UART_TX}, 32'd1);
        chk({tag, "_led"}, {24'b0, led},     32'h00);
        chk({tag, "_d1"},  {25'b0, digi1},   {25'b0, S0});
        chk({tag, "_d2"},  {25'b0, digi2},   {25'b0, S0});
        chk({tag, "_d3"},  {25'b0, digi3},   {25'b0, S0});
        chk({tag, "_d4"},  {25'b0, digi4},   {25'b0, S0});
    endtask

    // Monitor: decode every frame on UART_TX and compare with the scoreboard.
    initial begin
        exp_t       e;
        logic [9:0] fr;
        forever begin
            @(negedge sysclk);
            if (reset === 1'b1 && UART_TX === 1'b0) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_tx actual=frame required=none");
                    repeat (10 * BIT) @(negedge sysclk);
                end else begin
                    e = q.pop_front();
                    chk("led",   {24'b0, led},   {24'b0, e.led});
                    chk("digi1", {25'b0, digi1}, {25'b0, e.d1});
                    chk("digi2", {25'b0, digi2}, {25'b0, e.d2});
                    chk("digi3", {25'b0, digi3}, {25'b0, e.d3});
                    chk("digi4", {25'b0, digi4}, {25'b0, e.d4});
                    repeat (BIT / 2 - 1) @(negedge sysclk);
                    fr[0] = UART_TX;
                    for (int i = 1; i < 10; i++) begin
                        repeat (BIT) @(negedge sysclk);
                        fr[i] = UART_TX;
                    end
                    chk("tx_frame", {22'b0, fr}, {22'b0, 1'b1, e.res, 1'b0});
                end
            end
        end
    end

    initial begin
        reset = 1'b1;
        #1 reset = 1'b0;
        #1;
        chk_reset_outputs("rst_in");
        reset = 1'b1;
        cyc(5);
        chk_reset_outputs("rst_out");

        // gcd(0x18,0x78)=0x18, led shows result then operand B
        pair(8'h18, 8'h78, 8'h00, 8'h18, 8'h18, S1, S8, S1, S8);
        pair(8'h18, 8'h78, 8'h01, 8'h18, 8'h78, S1, S8, S1, S8);
        // zero operand, equal operands
        pair(8'h00, 8'h07, 8'h00, 8'h07, 8'h07, S0, S0, S0, S7);
        pair(8'hFF, 8'hFF, 8'h00, 8'hFF, 8'hFF, SF, SF, SF, SF);

        // framing error: byte dropped, A stays 0xFF
        send_byte(8'h55, 1'b0);
        cyc(BIT);
        chk("ferr_d1", {25'b0, digi1}, {25'b0, SF});
        chk("ferr_d2", {25'b0, digi2}, {25'b0, SF});
        chk("ferr_led", {24'b0, led}, 32'hFF);
        // next pair still pairs up correctly: gcd(12,18)=6
        pair(8'h0C, 8'h12, 8'h00, 8'h06, 8'h06, S0, SC, S0, S6);
        // gcd(0,0)=0
        pair(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, S0, S0, S0, S0);

        // reset in the middle of a long CALC (255,1 needs ~254 steps)
        send_byte(8'hFF, 1'b1);
        send_byte(8'h01, 1'b1);
        cyc(20);
        reset = 1'b0;
        #1;
        chk_reset_outputs("calc_rst");
        cyc(3);
        reset = 1'b1;
        cyc(400);
        chk("calc_rst_tx_idle", {31'b0, UART_TX}, 32'd1);
        // gcd(35,14)=7 after the aborted computation
        pair(8'h23, 8'h0E, 8'h00, 8'h07, 8'h07, S2, S3, S0, S7);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
